// File: rtl/fft_pkg.sv
// Shared FFT types: reorder-stage state encoding and the complex sample payload.
package fft_pkg;

    localparam int unsigned CPLX_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } bfly_reorder_state_t;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/bfly_reorder_mem.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module bfly_reorder_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned DW    = 20
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]            rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bfly_reorder.sv
// Butterfly output reorder: X1 streams through, X2 is buffered and replayed after the last X1.
// Build option BFLY_REORDER_SCALE_EN halves every output sample with round-half-up.
module bfly_reorder
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned HALF  = 256
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] din1_re,
    input  logic [WIDTH-1:0] din1_im,
    input  logic [WIDTH-1:0] din2_re,
    input  logic [WIDTH-1:0] din2_im,
    output logic [WIDTH-1:0] dout_re,
    output logic [WIDTH-1:0] dout_im,
    output logic             valid_out,
    output logic             frame_last
);

    localparam int unsigned AW = $clog2(HALF);
    localparam int unsigned DW = 2 * WIDTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(HALF - 1);

`ifdef BFLY_REORDER_SCALE_EN
    function automatic logic [WIDTH-1:0] out_fn(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] t;
        t = {x[WIDTH-1], x} + (WIDTH+1)'(1);
        return WIDTH'(t >> 1);
    endfunction
`else
    function automatic logic [WIDTH-1:0] out_fn(input logic [WIDTH-1:0] x);
        return x;
    endfunction
`endif

    bfly_reorder_state_t state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] dout_re_q, dout_re_d;
    logic [WIDTH-1:0] dout_im_q, dout_im_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             ready_q, ready_d;

    logic             xfer;
    logic             mem_we;
    logic             rd_adv;
    logic [DW-1:0]    rdata;

    assign xfer = valid_in && ready_q;

    bfly_reorder_mem #(
        .DEPTH (HALF),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({din2_re, din2_im}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Next-state: the first read is issued on the last PASS transfer to hide RAM latency.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dout_re_d = dout_re_q;
        dout_im_d = dout_im_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        mem_we    = 1'b0;
        rd_adv    = 1'b0;

        case (state_q)
            IDLE, PASS: begin
                if (xfer) begin
                    dout_re_d = out_fn(din1_re);
                    dout_im_d = out_fn(din1_im);
                    valid_d   = 1'b1;
                    mem_we    = 1'b1;
                    wr_ptr_d  = wr_ptr_q + AW'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                        rd_adv  = 1'b1;
                    end else begin
                        state_d = PASS;
                        cnt_d   = cnt_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                dout_re_d = out_fn(rdata[DW-1:WIDTH]);
                dout_im_d = out_fn(rdata[WIDTH-1:0]);
                valid_d   = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    last_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + AW'(1);
                    rd_adv = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        ready_d = (state_d != DRAIN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            dout_re_q <= '0;
            dout_im_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dout_re_q <= dout_re_d;
            dout_im_q <= dout_im_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_in   = ready_q;
    assign dout_re    = dout_re_q;
    assign dout_im    = dout_im_q;
    assign valid_out  = valid_q;
    assign frame_last = last_q;

endmodule

// File: tb/tb_bfly_reorder.sv
// Self-checking bench for bfly_reorder against a queue-based frame model.
module tb_bfly_reorder;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned HALF  = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] din1_re, din1_im, din2_re, din2_im;
    logic [WIDTH-1:0] dout_re, dout_im;
    logic             valid_out;
    logic             frame_last;

    int checks = 0;
    int errors = 0;

    // Model: accepted differences wait in a queue; after HALF pairs the stage is busy HALF cycles.
    int diff_re_q[$];
    int diff_im_q[$];
    int acc = 0;
    int drain_left = 0;

    always #5 clk = ~clk;

    bfly_reorder #(
        .WIDTH (WIDTH),
        .HALF  (HALF)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .din1_re    (din1_re),
        .din1_im    (din1_im),
        .din2_re    (din2_re),
        .din2_im    (din2_im),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .valid_out  (valid_out),
        .frame_last (frame_last)
    );

    function automatic int ref_out(input int x);
`ifdef BFLY_REORDER_SCALE_EN
        return (x + 1) >>> 1;
`else
        return x;
`endif
    endfunction

    function automatic int rnd_s();
        return int'($urandom_range(1023)) - 512;
    endfunction

    task automatic step(input logic v, input int s_re, input int s_im,
                        input int d_re, input int d_im);
        logic             model_ready;
        logic             exp_valid;
        logic             exp_last;
        int               exp_re;
        int               exp_im;
        logic [WIDTH-1:0] want_re;
        logic [WIDTH-1:0] want_im;
        @(negedge clk);
        valid_in = v;
        din1_re  = WIDTH'(s_re);
        din1_im  = WIDTH'(s_im);
        din2_re  = WIDTH'(d_re);
        din2_im  = WIDTH'(d_im);
        model_ready = (drain_left == 0);
        checks++;
        if (ready_in !== model_ready) begin
            errors++;
            $display("FAIL ready_in t=%0t got %b exp %b", $time, ready_in, model_ready);
        end
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_re    = 0;
        exp_im    = 0;
        if (drain_left > 0) begin
            exp_valid = 1'b1;
            exp_re    = ref_out(diff_re_q.pop_front());
            exp_im    = ref_out(diff_im_q.pop_front());
            drain_left--;
            exp_last  = (drain_left == 0);
        end else if (v) begin
            exp_valid = 1'b1;
            exp_re    = ref_out(s_re);
            exp_im    = ref_out(s_im);
            diff_re_q.push_back(d_re);
            diff_im_q.push_back(d_im);
            acc++;
            if (acc == int'(HALF)) begin
                acc        = 0;
                drain_left = int'(HALF);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== exp_valid) begin
            errors++;
            $display("FAIL valid_out t=%0t got %b exp %b", $time, valid_out, exp_valid);
        end
        checks++;
        if (frame_last !== exp_last) begin
            errors++;
            $display("FAIL frame_last t=%0t got %b exp %b", $time, frame_last, exp_last);
        end
        if (exp_valid) begin
            want_re = WIDTH'(exp_re);
            want_im = WIDTH'(exp_im);
            checks++;
            if (dout_re !== want_re) begin
                errors++;
                $display("FAIL dout_re t=%0t got %0d exp %0d", $time, $signed(dout_re), $signed(want_re));
            end
            checks++;
            if (dout_im !== want_im) begin
                errors++;
                $display("FAIL dout_im t=%0t got %0d exp %0d", $time, $signed(dout_im), $signed(want_im));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        valid_in = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || frame_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got valid=%b last=%b exp 0 0", valid_out, frame_last);
        end
        checks++;
        if (dout_re !== '0 || dout_im !== '0) begin
            errors++;
            $display("FAIL reset_dout got %0d/%0d exp 0/0", $signed(dout_re), $signed(dout_im));
        end
        diff_re_q.delete();
        diff_im_q.delete();
        acc        = 0;
        drain_left = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        idle(3);
        checks++;
        if (dout_re !== '0 || dout_im !== '0) begin
            errors++;
            $display("FAIL idle_dout got %0d/%0d exp 0/0", $signed(dout_re), $signed(dout_im));
        end
    endtask

    task automatic test_contiguous();
        for (int i = 1; i <= int'(HALF); i++) step(1'b1, i, i, -i, -i);
        idle(int'(HALF) + 2);
    endtask

    task automatic test_gapped();
        for (int i = 1; i <= int'(HALF); i++) begin
            step(1'b1, i, i, -i, -i);
            idle(1);
        end
        // valid_in held high with junk while the stage drains
        for (int i = 0; i < int'(HALF) - 1; i++) step(1'b1, rnd_s(), rnd_s(), rnd_s(), rnd_s());
        for (int i = 0; i < int'(HALF); i++) step(1'b1, 100 + i, -100 - i, 200 + i, -200 - i);
        idle(int'(HALF) + 2);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 511, -512, -512, 511);
        step(1'b1, -512, 511, 511, -512);
        for (int i = 0; i < 4 * int'(HALF) - 2; i++) step(1'b1, rnd_s(), rnd_s(), rnd_s(), rnd_s());
        idle(int'(HALF) + 2);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < int'(HALF); i++) step(1'b1, rnd_s(), rnd_s(), rnd_s(), rnd_s());
        idle(2);
        do_reset();
        for (int i = 0; i < int'(HALF); i++) step(1'b1, 10 + i, 10 + i, 20 + i, 20 + i);
        idle(int'(HALF) + 2);
    endtask

    task automatic test_scale_points();
        step(1'b1, 511, -512, 511, -512);
        step(1'b1, 3, -3, 3, -3);
        step(1'b1, -512, 511, -512, 511);
        step(1'b1, -3, 3, -3, 3);
        idle(int'(HALF) + 1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 2 * int'(HALF); i++) begin
                if ($urandom_range(3) == 0) step(1'b0, 0, 0, 0, 0);
                else step(1'b1, rnd_s(), rnd_s(), rnd_s(), rnd_s());
            end
        end
        idle(2 * int'(HALF) + 2);
    endtask

    initial begin
        rstn     = 1'b0;
        valid_in = 1'b0;
        din1_re  = '0;
        din1_im  = '0;
        din2_re  = '0;
        din2_im  = '0;
        test_reset();
        test_contiguous();
        test_gapped();
        test_back_to_back();
        test_mid_reset();
        test_scale_points();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
